// File: rtl/spi_pkg.sv
// Shared SPI definitions for the byte transmitter and receiver.
// Frame receiver states and default word/synchronizer sizes.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
// Adds a previous-value register so rise/fall are one-clk pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave deserializer, MSB first, oversampled in clk.
// Emits words on valid/ready; flags partial frames and overruns.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  spi_rx_state_t r_state;
  spi_rx_state_t w_state_n;

  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic               r_done;
  logic               r_ferr;
  logic               r_ovr;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic [SYNC_STAGES:0] r_warm;

  logic w_sclk_rise;
  logic w_sclk_lvl_unused;
  logic w_sclk_fall_unused;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_cs_lvl_unused;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;
  logic w_start;
  logic w_busy;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk     (clk),
    .rst     (rst),
    .i_din   (sclk),
    .o_level (w_sclk_lvl_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk     (clk),
    .rst     (rst),
    .i_din   (cs),
    .o_level (w_cs_lvl_unused),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk     (clk),
    .rst     (rst),
    .i_din   (mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  // The cs synchronizer resets high; a pin already low would look like
  // a fall once it flushes, so falls are ignored until it has.
  always_ff @(posedge clk) begin
    if (!rst) r_warm <= '0;
    else      r_warm <= {r_warm[SYNC_STAGES-1:0], 1'b1};
  end

  assign w_start = w_cs_fall & r_warm[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (w_start)   w_state_n = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state == SHIFT) w_busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      if (r_state == IDLE) begin
        if (w_start) r_cnt <= '0;
      end else if (w_cs_rise) begin
        r_ferr <= (r_cnt != '0);
        r_cnt  <= '0;
      end else if (w_sclk_rise) begin
        r_shift <= {r_shift[DATA_W-2:0], w_mosi};
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = w_busy;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: framing, handshake, overrun,
// partial frames and mid-frame reset.
module tb_spi_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;

  int         acc_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] acc_mem [0:63];

  spi_byte_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  // Record each accepted word and every cycle a pulse output is high.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid && rx_ready) begin
      acc_mem[acc_cnt[5:0]] = rx_data;
      acc_cnt++;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic rise_bit(input logic b);
    @(negedge clk);
    mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
  endtask

  task automatic fall_sclk();
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] d, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      rise_bit(d[i]);
      fall_sclk();
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid);
    end
    total++;
    if (rx_data !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h exp=00", rx_data);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    total++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses got=%b%b exp=00", frame_err, overrun);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int a0, f0, o0, n;
    d = 8'h93;
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    cs_low();
    send_range(d, 7, 1);
    rise_bit(d[0]);
    n = 0;
    while (rx_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL single_latency got=%0d exp=4", n);
    end
    fall_sclk();
    cs_high();
    total++;
    if (acc_cnt - a0 !== 1) begin
      bad++; $display("FAIL single_count got=%0d exp=1", acc_cnt - a0);
    end
    total++;
    if (acc_mem[a0[5:0]] !== 8'h93) begin
      bad++; $display("FAIL single_data got=%h exp=93", acc_mem[a0[5:0]]);
    end
    total++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      bad++;
      $display("FAIL single_flags got=%0d/%0d exp=0/0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_multi();
    int a0;
    a0 = acc_cnt;
    rx_ready = 1'b1;
    cs_low();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL multi_busy_start got=%b exp=1", busy);
    end
    send_range(8'hA5, 7, 0);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL multi_busy_mid got=%b exp=1", busy);
    end
    send_range(8'h3C, 7, 0);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL multi_busy_end got=%b exp=1", busy);
    end
    cs_high();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL multi_busy_idle got=%b exp=0", busy);
    end
    total++;
    if (acc_cnt - a0 !== 2) begin
      bad++; $display("FAIL multi_count got=%0d exp=2", acc_cnt - a0);
    end
    total++;
    if (acc_mem[a0[5:0]] !== 8'hA5) begin
      bad++; $display("FAIL multi_w0 got=%h exp=a5", acc_mem[a0[5:0]]);
    end
    a0++;
    total++;
    if (acc_mem[a0[5:0]] !== 8'h3C) begin
      bad++; $display("FAIL multi_w1 got=%h exp=3c", acc_mem[a0[5:0]]);
    end
  endtask

  task automatic test_back_to_back();
    int a0, o0;
    a0 = acc_cnt; o0 = ovr_cnt;
    rx_ready = 1'b0;
    cs_low();
    send_range(8'h11, 7, 0);
    send_range(8'h22, 7, 0);
    cs_high();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      bad++;
      $display("FAIL bp_hold got=%b/%h exp=1/11", rx_valid, rx_data);
    end
    total++;
    if (ovr_cnt - o0 !== 1) begin
      bad++; $display("FAIL bp_overrun got=%0d exp=1", ovr_cnt - o0);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    rx_ready = 1'b0;
    total++;
    if (acc_cnt - a0 !== 1 || acc_mem[a0[5:0]] !== 8'h11) begin
      bad++;
      $display("FAIL bp_drain got=%0d/%h exp=1/11",
               acc_cnt - a0, acc_mem[a0[5:0]]);
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    int a0, o0;
    d = 8'h22;
    a0 = acc_cnt; o0 = ovr_cnt;
    rx_ready = 1'b0;
    cs_low();
    send_range(8'h11, 7, 0);
    send_range(d, 7, 1);
    rise_bit(d[0]);
    repeat (3) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      bad++;
      $display("FAIL same_load got=%b/%h exp=1/22", rx_valid, rx_data);
    end
    total++;
    if (ovr_cnt - o0 !== 0) begin
      bad++; $display("FAIL same_overrun got=%0d exp=0", ovr_cnt - o0);
    end
    fall_sclk();
    cs_high();
    total++;
    if (acc_cnt - a0 !== 2) begin
      bad++; $display("FAIL same_count got=%0d exp=2", acc_cnt - a0);
    end
    total++;
    if (acc_mem[a0[5:0]] !== 8'h11) begin
      bad++; $display("FAIL same_w0 got=%h exp=11", acc_mem[a0[5:0]]);
    end
    a0++;
    total++;
    if (acc_mem[a0[5:0]] !== 8'h22) begin
      bad++; $display("FAIL same_w1 got=%h exp=22", acc_mem[a0[5:0]]);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_partial();
    int a0, f0;
    a0 = acc_cnt; f0 = ferr_cnt;
    rx_ready = 1'b1;
    cs_low();
    send_range(8'hFF, 7, 3);
    cs_high();
    total++;
    if (ferr_cnt - f0 !== 1) begin
      bad++; $display("FAIL partial_ferr got=%0d exp=1", ferr_cnt - f0);
    end
    total++;
    if (acc_cnt - a0 !== 0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL partial_valid got=%0d/%b exp=0/0",
               acc_cnt - a0, rx_valid);
    end
    cs_low();
    send_range(8'h5A, 7, 0);
    cs_high();
    total++;
    if (acc_cnt - a0 !== 1 || acc_mem[a0[5:0]] !== 8'h5A) begin
      bad++;
      $display("FAIL partial_next got=%0d/%h exp=1/5a",
               acc_cnt - a0, acc_mem[a0[5:0]]);
    end
    total++;
    if (ferr_cnt - f0 !== 1) begin
      bad++; $display("FAIL partial_ferr2 got=%0d exp=1", ferr_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    int a0, f0;
    a0 = acc_cnt; f0 = ferr_cnt;
    rx_ready = 1'b1;
    cs_low();
    send_range(8'hF0, 7, 5);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_range(8'hF0, 4, 0);
    repeat (6) @(negedge clk);
    total++;
    if (acc_cnt - a0 !== 0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_valid got=%0d/%b exp=0/0",
               acc_cnt - a0, rx_valid);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy got=%b exp=0", busy);
    end
    cs_high();
    total++;
    if (ferr_cnt - f0 !== 0) begin
      bad++; $display("FAIL rstmid_ferr got=%0d exp=0", ferr_cnt - f0);
    end
    cs_low();
    send_range(8'h81, 7, 0);
    cs_high();
    total++;
    if (acc_cnt - a0 !== 1 || acc_mem[a0[5:0]] !== 8'h81) begin
      bad++;
      $display("FAIL rstmid_next got=%0d/%h exp=1/81",
               acc_cnt - a0, acc_mem[a0[5:0]]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_same_cycle();
    test_partial();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_rx.md
Name: spi_byte_rx

Overview:
- SPI slave-side deserializer. Consumes the mosi/sclk/cs stream produced by the team's SPI byte transmitter (mode 0, MSB first; transmitter launches data on sclk falling edge).
- Oversamples all three lines in the local clk domain and emits each completed byte on a valid/ready interface.
- Flags partial frames and overruns.
- Sits between the SPI pins and the downstream audio/command consumer.

Parameters:
- DATA_W, 8, bits per word; shifted MSB first.
- SYNC_STAGES, 2, flip-flops in each input synchronizer; identical on sclk, cs and mosi so their relative alignment is preserved.

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency (50 MHz vs 4 MHz nominal).
- rst  in  1  synchronous, active-low reset, sampled on clk rising edge.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs  in  1  SPI chip select, active-low, asynchronous.
- mosi  in  1  SPI serial data, asynchronous.
- rx_data  out  DATA_W  received word; stable while rx_valid=1.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready on a clk edge.
- frame_err  out  1  one-clk pulse: cs rose with a partial word pending.
- overrun  out  1  one-clk pulse: a word completed while rx_valid=1 and rx_ready=0; the new word is dropped.
- busy  out  1  high while state = SHIFT.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, bit_cnt=0, shift=0, rx_data=0.
  - rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops cleared to sclk=0, cs=1, mosi=0.
- Edge detect: compare the synced value with its previous value.
  - sclk_rise = synced sclk 0->1.
  - cs_fall = synced cs 1->0.
  - cs_rise = synced cs 0->1.
- FSM states: IDLE, SHIFT.
  - IDLE:
    - On cs_fall: go to SHIFT; bit_cnt=0.
    - A cs held low out of reset does not start a frame. Only a cs_fall does.
  - SHIFT, on sclk_rise:
    - shift <= {shift[DATA_W-2:0], synced mosi}.
    - bit_cnt++.
    - When bit_cnt was DATA_W-1: bit_cnt wraps to 0 and the assembled word completes. Stay in SHIFT (multi-word frames allowed).
  - SHIFT, on cs_rise:
    - Go to IDLE.
    - If bit_cnt != 0, pulse frame_err for one cycle and discard the partial word.
    - cs_rise takes priority over an sclk_rise in the same cycle; that bit is discarded.
- Word completion, in the cycle after the final sclk_rise:
  - If rx_valid=0, or rx_valid=1 && rx_ready=1 (simultaneous consume and load): rx_data <= word, rx_valid <= 1, no overrun.
  - Otherwise: overrun pulses for one cycle; rx_data and rx_valid are unchanged.
- Handshake:
  - rx_valid falls the cycle after rx_valid && rx_ready, unless a new word loads in that same cycle.
  - rx_ready is ignored while rx_valid=0.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the pin-level sclk rising edge of the last bit.
- Reset mid-frame: everything clears; the remainder of the frame is ignored until the next cs_fall.
- Outputs frame_err and overrun are registered; no combinational path from input to output.

Decomposition:
- spi_pkg (shared with the transmitter):
  - spi_rx_state_t enum {IDLE, SHIFT}.
  - localparam SPI_DATA_W = 8.
  - localparam SPI_SYNC_STAGES = 2.
- Sub-module spi_sync_edge:
  - Parameterised SYNC_STAGES synchronizer plus previous-value register.
  - Outputs: level, rise, fall.
  - Instantiated for sclk and cs. mosi uses the same synchronizer; its edge outputs are left unused.

Test Plan:
- Single frame: cs low, 8 bits 0x93, cs high; rx_ready=1 -> one rx_valid pulse with rx_data=0x93, frame_err=0, overrun=0.
- Multi-word frame: 0xA5 then 0x3C within one cs-low window; rx_ready=1 -> two accepted words 0xA5, 0x3C in order; busy high throughout.
- Back-pressure: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once after the 16th bit; raising rx_ready then drains 0x11 only.
- Same-cycle consume/load: rx_ready asserted exactly in the completion cycle of the second word -> 0x22 loads, rx_valid stays 1, no overrun.
- Partial frame: 5 bits then cs high -> frame_err one-cycle pulse, rx_valid stays 0; the next full frame 0x5A is received correctly.
- Reset mid-frame: rst low after 3 bits of 0xF0 while cs is still low, released with cs low; remaining bits sent -> no rx_valid; the next cs_fall with 0x81 yields rx_data=0x81.
